// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory access arbiter.
package mem_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    localparam logic REQ_ID_0 = 1'b0;
    localparam logic REQ_ID_1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Request/response handshakes for both requesters plus the memory pins.
interface mem_access_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
);
    logic              r0_req_valid;
    logic              r0_req_ready;
    logic              r0_req_we;
    logic [ADDR_W-1:0] r0_req_addr;
    logic [DATA_W-1:0] r0_req_wdata;
    logic              r0_rsp_valid;
    logic [DATA_W-1:0] r0_rsp_rdata;

    logic              r1_req_valid;
    logic              r1_req_ready;
    logic              r1_req_we;
    logic [ADDR_W-1:0] r1_req_addr;
    logic [DATA_W-1:0] r1_req_wdata;
    logic              r1_rsp_valid;
    logic [DATA_W-1:0] r1_rsp_rdata;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_writeData;
    logic              mem_writeEnable;
    logic [DATA_W-1:0] mem_readData;

    // Requesters together with the memory model
    modport master (
        output r0_req_valid, r0_req_we, r0_req_addr, r0_req_wdata,
        input  r0_req_ready, r0_rsp_valid, r0_rsp_rdata,
        output r1_req_valid, r1_req_we, r1_req_addr, r1_req_wdata,
        input  r1_req_ready, r1_rsp_valid, r1_rsp_rdata,
        input  mem_address, mem_writeData, mem_writeEnable,
        output mem_readData
    );

    modport slave (
        input  r0_req_valid, r0_req_we, r0_req_addr, r0_req_wdata,
        output r0_req_ready, r0_rsp_valid, r0_rsp_rdata,
        input  r1_req_valid, r1_req_we, r1_req_addr, r1_req_wdata,
        output r1_req_ready, r1_rsp_valid, r1_rsp_rdata,
        output mem_address, mem_writeData, mem_writeEnable,
        input  mem_readData
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection; round-robin when MEM_ARB_ROUND_ROBIN_EN is
// defined, otherwise fixed priority to port 0.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic last_grant,
`endif
    output logic grant_id
);

    // Winner: on a tie prefer the port not granted last (or port 0 when fixed)
    always_comb begin
        grant_id = REQ_ID_0;
        if (valid0 && valid1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            grant_id = ~last_grant;
`else
            grant_id = REQ_ID_0;
`endif
        end else if (valid1) begin
            grant_id = REQ_ID_1;
        end else begin
            grant_id = REQ_ID_0;
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Two-port arbiter and IDLE->ACCESS->RESP sequencer for a word-accessed memory.
// Optional round-robin arbitration via MEM_ARB_ROUND_ROBIN_EN.
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_access_arbiter_if.slave bus
);

    localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    arb_state_t        state_r;
    arb_state_t        state_nxt_s;
    logic              grant_id_s;
    logic              hs_s;
    logic              ready0_s;
    logic              ready1_s;
    logic              win_we_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_wdata_s;

    logic              owner_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              rsp0_valid_r;
    logic              rsp1_valid_r;
    logic [DATA_W-1:0] rsp0_rdata_r;
    logic [DATA_W-1:0] rsp1_rdata_r;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              last_grant_r;
`endif

    mem_arb_pick u_pick (
        .valid0     (bus.r0_req_valid),
        .valid1     (bus.r1_req_valid),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_grant (last_grant_r),
`endif
        .grant_id   (grant_id_s)
    );

    // Request fields of the current winner
    always_comb begin
        if (grant_id_s == REQ_ID_1) begin
            win_we_s    = bus.r1_req_we;
            win_addr_s  = bus.r1_req_addr;
            win_wdata_s = bus.r1_req_wdata;
        end else begin
            win_we_s    = bus.r0_req_we;
            win_addr_s  = bus.r0_req_addr;
            win_wdata_s = bus.r0_req_wdata;
        end
    end

    // Next state and combinational ready; only IDLE accepts requests
    always_comb begin
        state_nxt_s = state_r;
        ready0_s    = 1'b0;
        ready1_s    = 1'b0;
        hs_s        = 1'b0;
        case (state_r)
            IDLE: begin
                ready0_s = bus.r0_req_valid & (grant_id_s == REQ_ID_0);
                ready1_s = bus.r1_req_valid & (grant_id_s == REQ_ID_1);
                hs_s     = ready0_s | ready1_s;
                if (hs_s) begin
                    state_nxt_s = ACCESS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS:  state_nxt_s = RESP;
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Latch the granted request; write strobe is live only during ACCESS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_r  <= REQ_ID_0;
            mem_we_r <= 1'b0;
            addr_r   <= ADDR_ZERO;
            wdata_r  <= DATA_ZERO;
        end else begin
            mem_we_r <= hs_s & win_we_s;
            if (hs_s) begin
                owner_r <= grant_id_s;
                addr_r  <= win_addr_s & ADDR_MASK;
                wdata_r <= win_wdata_s;
            end
        end
    end

    // Capture read data at the end of ACCESS into the owner's response slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            rsp0_rdata_r <= DATA_ZERO;
            rsp1_rdata_r <= DATA_ZERO;
        end else begin
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            rsp0_rdata_r <= DATA_ZERO;
            rsp1_rdata_r <= DATA_ZERO;
            if (state_r == ACCESS) begin
                if (owner_r == REQ_ID_1) begin
                    rsp1_valid_r <= 1'b1;
                    rsp1_rdata_r <= mem_we_r ? DATA_ZERO : bus.mem_readData;
                end else begin
                    rsp0_valid_r <= 1'b1;
                    rsp0_rdata_r <= mem_we_r ? DATA_ZERO : bus.mem_readData;
                end
            end
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Last-grant register; reset value 1 lets port 0 win the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= REQ_ID_1;
        end else if (hs_s) begin
            last_grant_r <= grant_id_s;
        end
    end
`endif

    assign bus.r0_req_ready    = ready0_s;
    assign bus.r1_req_ready    = ready1_s;
    assign bus.r0_rsp_valid    = rsp0_valid_r;
    assign bus.r1_rsp_valid    = rsp1_valid_r;
    assign bus.r0_rsp_rdata    = rsp0_rdata_r;
    assign bus.r1_rsp_rdata    = rsp1_rdata_r;
    assign bus.mem_address     = addr_r;
    assign bus.mem_writeData   = wdata_r;
    assign bus.mem_writeEnable = mem_we_r;

endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

Two-port arbiter and access sequencer placed in front of the byte-organised, word-accessed data memory. Two requesters (typically a fetch path and a load/store path) issue word reads and writes over valid/ready handshakes. The block grants one request at a time, drives the memory's address, write-data and write-enable pins for exactly one cycle, and returns a registered response to the granted requester.

## Interface
- `ADDR_W`, 32: address width in bits.
- `DATA_W`, 32: data word width in bits.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `r0_req_valid`, `r1_req_valid` in 1: request present.
- `r0_req_ready`, `r1_req_ready` out 1: request accepted this cycle.
- `r0_req_we`, `r1_req_we` in 1: 1 = write, 0 = read.
- `r0_req_addr`, `r1_req_addr` in ADDR_W: byte address.
- `r0_req_wdata`, `r1_req_wdata` in DATA_W: write data.
- `r0_rsp_valid`, `r1_rsp_valid` out 1: one-cycle response pulse.
- `r0_rsp_rdata`, `r1_rsp_rdata` out DATA_W: read data; 0 for writes.
- `mem_address` out ADDR_W: memory address, low 2 bits always 0.
- `mem_writeData` out DATA_W: memory write data.
- `mem_writeEnable` out 1: memory write strobe.
- `mem_readData` in DATA_W: combinational read data from memory.

## Operation
- The FSM has three states: IDLE → ACCESS → RESP → IDLE. There is no other path except reset.
- **IDLE:**
  - The winner's `req_ready` is driven combinationally high whenever that requester's valid is high. The loser's ready is 0.
  - A handshake is valid && ready. On a handshake, the block latches the owner ID, we, {addr[ADDR_W-1:2], 2'b00}, and wdata, then moves to ACCESS.
- **ACCESS:**
  - `mem_address` and `mem_writeData` come from the latched registers.
  - `mem_writeEnable` equals the latched we. It is high only in this state.
  - `mem_readData` is captured into the rdata register at the end of the cycle; 0 is captured for writes. The FSM then moves to RESP.
- **RESP:**
  - The owner's `rsp_valid` is 1 and its `rsp_rdata` carries the rdata register. The other port's response outputs stay 0.
  - The FSM moves to IDLE. No request is accepted in this state.
- Both `req_ready` outputs are 0 in ACCESS and RESP.
- Requesters hold valid, we, addr and wdata stable until the handshake.
- Address bits [1:0] are discarded. No misalignment error is raised.
- Arbitration with both requests valid in IDLE:
  - With round-robin enabled, the winner is the port not granted last. The last-grant register resets to 1, so port 0 wins the first tie.
  - A lone request always wins.
- **Reset mid-operation:**
  - Asserting `rst_n` low forces IDLE immediately.
  - `mem_writeEnable` drops asynchronously, so a write in ACCESS is not committed if reset arrives before the edge.
  - No response is issued for the aborted request.

## Timing
- All outputs reset to 0: rsp_valid, rsp_rdata, mem_address, mem_writeData, mem_writeEnable, and the internal registers. `req_ready` is combinational from IDLE and valid, so it can be 1 in the first cycle after reset release.
- Handshake in cycle N (IDLE). The memory access occurs in cycle N+1, and a write commits at the end of N+1.
- `rsp_valid` is high in cycle N+2. The next handshake is possible in N+3, giving a peak throughput of one access per 3 cycles.
- Memory outputs hold their latched values in IDLE and RESP. Only `mem_writeEnable` is gated.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`:
  - **Defined:** round-robin arbitration using the last-grant register, updated on every handshake.
  - **Undefined:** fixed priority; port 0 always wins a tie. The last-grant register is not built.

## Structure
- **Package `mem_arb_pkg`:**
  - `arb_state_t` enum {IDLE, ACCESS, RESP}.
  - Constants `REQ_ID_0` = 0 and `REQ_ID_1` = 1.
  - The default ADDR_W/DATA_W values.
- **Sub-module `mem_arb_pick`:**
  - Combinational winner selection from the two valids plus the last-grant bit.
  - Contains the macro-dependent logic.

## Test plan
- **Reset:** hold `rst_n` low with both valids high. All outputs except ready are 0. After release, `r0_req_ready` is 1 in the first IDLE cycle.
- **Write then read:** r0 writes 0xDEADBEEF to 0x10.
  - `mem_writeEnable` is high for exactly 1 cycle at N+1, and `r0_rsp_valid` is high at N+2 with rdata 0.
  - r1 then reads 0x10: `r1_rsp_rdata` is 0xDEADBEEF at handshake+2, and `r0_rsp_valid` stays 0.
- **Contention:** both ports hold valid for 8 grants.
  - With the macro, grants go 0,1,0,1,…
  - Without it, all 8 grants go to port 0, and port 1 is never ready.
- **Alignment:** a read of 0x13 drives `mem_address` to 0x10 and returns the word at 0x10.
- **Reset abort:** pull `rst_n` low mid-cycle during ACCESS of a write of 0x12345678 to 0x20.
  - `mem_writeEnable` falls immediately, and memory at 0x20 is unchanged.
  - No `rsp_valid` is issued.
- **Back-to-back:** r0 keeps valid high continuously. Handshakes occur every 3 cycles, and ready is never high in ACCESS or RESP.
